// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and cycle-count helpers for systolic_feeder.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Cycles needed to push a full skewed wavefront into an n-wide edge.
    function automatic int feed_cyc(input int n, input int k);
        return k + n - 1;
    endfunction

    // Cycles for the last operand to ripple through n PE hops.
    function automatic int drain_cyc(input int n, input int pe_lat);
        return (n - 1) * pe_lat + pe_lat;
    endfunction

endpackage

// File: rtl/feeder_edge.sv
// feeder_edge: registers one skewed array edge (N lanes) from a matrix snapshot.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : the next cycle is a FEED cycle
//   i_step         : step index that the next cycle presents
//   i_mat          : row-major snapshot, element 0 in the MSBs
//   o_data, o_vld  : lane l at [W*l +: W], registered
// TRANSPOSE = 0 walks lane l along row l (A, west edge); TRANSPOSE = 1 walks
// lane l down column l (B, north edge). ROW_STRIDE is the snapshot row length.
module feeder_edge #(
    parameter int W          = 16,
    parameter int N          = 3,
    parameter int K          = 3,
    parameter int ROW_STRIDE = 3,
    parameter bit TRANSPOSE  = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [$clog2(K+N)-1:0]  i_step,
    input  logic [W*N*K-1:0]        i_mat,
    output logic [W*N-1:0]          o_data,
    output logic [N-1:0]            o_vld
);

    logic [W*N-1:0] nxt_data;
    logic [N-1:0]   nxt_vld;

    always_comb begin
        nxt_data = '0;
        nxt_vld  = '0;
        for (int i = 0; i < N; i++) begin
            int s;
            int idx;
            // lane i lags lane 0 by i steps
            s   = int'(i_step) - i;
            idx = TRANSPOSE ? s * ROW_STRIDE + i : i * ROW_STRIDE + s;
            if (i_en && s >= 0 && s < K) begin
                nxt_vld[i]          = 1'b1;
                nxt_data[W*i +: W]  = W'(i_mat >> (W * (N * K - 1 - idx)));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_vld  <= '0;
        end else begin
            o_data <= nxt_data;
            o_vld  <= nxt_vld;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: snapshots A (NxK) and B (KxN) and streams them skewed into an NxN PE array.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_start, i_acc     : start request (IDLE only); accumulate mode, latched with start
//   i_A, i_B           : row-major matrices, element [0][0] in the MSBs
//   o_a_row, o_a_vld   : west edge, lane i feeds PE row i
//   o_b_col, o_b_vld   : north edge, lane j feeds PE column j
//   o_clr              : one-cycle accumulator clear (LOAD, unless accumulating)
//   o_busy, o_done     : busy in LOAD/FEED/DRAIN; one-cycle done pulse
// Optional macro SYSTOLIC_FEEDER_DBG_EN adds o_d_state and o_d_a00 debug outputs.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int W      = 16,
    parameter int N      = 3,
    parameter int K      = 3,
    parameter int PE_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_acc,
    input  logic [W*N*K-1:0]   i_A,
    input  logic [W*K*N-1:0]   i_B,
    output logic [W*N-1:0]     o_a_row,
    output logic [N-1:0]       o_a_vld,
    output logic [W*N-1:0]     o_b_col,
    output logic [N-1:0]       o_b_vld,
    output logic               o_clr,
    output logic               o_busy,
    output logic               o_done
`ifdef SYSTOLIC_FEEDER_DBG_EN
    ,
    output logic [2:0]         o_d_state,
    output logic [W-1:0]       o_d_a00
`endif
);

    localparam int F  = feed_cyc(N, K);
    localparam int D  = drain_cyc(N, PE_LAT);
    localparam int TW = $clog2(K + N);
    localparam int DW = $clog2(D + 1);

    state_t             state, nxt_state;
    logic [TW-1:0]      t, nxt_t;
    logic [DW-1:0]      d, nxt_d;
    logic               acc_q;
    logic [W*N*K-1:0]   a_q, b_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            t     <= '0;
            d     <= '0;
            acc_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= nxt_state;
            t     <= nxt_t;
            d     <= nxt_d;
            if (state == IDLE && i_start) begin
                acc_q <= i_acc;
                a_q   <= i_A;
                b_q   <= i_B;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_t     = '0;
        nxt_d     = '0;
        case (state)
            IDLE:    nxt_state = i_start ? LOAD : IDLE;
            LOAD:    nxt_state = FEED;
            FEED:    if (t == TW'(F - 1)) nxt_state = DRAIN;
                     else nxt_t = t + 1'b1;
            DRAIN:   if (d == DW'(D - 1)) nxt_state = DONE;
                     else nxt_d = d + 1'b1;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Edges register the value for the coming cycle, so they look at next-state/next-step.
    feeder_edge #(.W(W), .N(N), .K(K), .ROW_STRIDE(K), .TRANSPOSE(1'b0)) u_west (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (nxt_state == FEED),
        .i_step  (nxt_t),
        .i_mat   (a_q),
        .o_data  (o_a_row),
        .o_vld   (o_a_vld)
    );

    feeder_edge #(.W(W), .N(N), .K(K), .ROW_STRIDE(N), .TRANSPOSE(1'b1)) u_north (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (nxt_state == FEED),
        .i_step  (nxt_t),
        .i_mat   (b_q),
        .o_data  (o_b_col),
        .o_vld   (o_b_vld)
    );

    assign o_clr  = (state == LOAD) && !acc_q;
    assign o_busy = state inside {LOAD, FEED, DRAIN};
    assign o_done = state == DONE;

`ifdef SYSTOLIC_FEEDER_DBG_EN
    assign o_d_state = state;
    assign o_d_a00   = a_q[W*N*K-1 -: W];
`endif

endmodule
